// File: rtl/prefetch_pkg.sv
// Shared types and default sizes for the instruction prefetch queue.
package prefetch_pkg;

    localparam int ADDR_W = 64;
    localparam int INSTR_W = 32;
    localparam logic [ADDR_W-1:0] RESET_PC = 64'h0;

    typedef enum logic {
        FETCH = 1'b0,
        FLUSH = 1'b1
    } pf_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } pf_entry_t;

endpackage

// File: rtl/prefetch_checker.sv
// Protocol checks for the instruction memory response channel.
module prefetch_checker (
    input logic clk_i,
    input logic rst_ni,
    input logic rsp_valid_i,
    input logic out_zero_i,
    input logic stale_zero_i
);

    rsp_without_request: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(rsp_valid_i && out_zero_i && stale_zero_i));

endmodule

// File: rtl/prefetch_fifo.sv
// Circular FIFO of {pc, instr} entries with push, pop, clear and occupancy count.
module prefetch_fifo
    import prefetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             push_i,
    input  pf_entry_t        push_data_i,
    input  logic             pop_i,
    output pf_entry_t        head_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    pf_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push_s;
    logic             do_pop_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? {PTR_W{1'b0}} : ptr + PTR_W'(1'b1);
    endfunction

    // A push at full is only accepted when the head leaves in the same cycle.
    always_comb begin
        do_pop_s  = pop_i && (count_q != {CNT_W{1'b0}});
        do_push_s = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop_s);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop_s)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_q + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
        end
    end

    // Entry storage.
    always_ff @(posedge clk_i) begin
        if (do_push_s) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/instr_prefetch_queue.sv
// Sequential instruction prefetcher with credit-limited requests and redirect flush.
// Define PREFETCH_BYPASS_EN to forward a response to IF in its arrival cycle when the queue is empty.
module instr_prefetch_queue #(
    parameter int DEPTH = 4,
    parameter int ADDR_W = prefetch_pkg::ADDR_W,
    parameter int INSTR_W = prefetch_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = prefetch_pkg::RESET_PC
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr_data,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_ready
);
    import prefetch_pkg::*;

    localparam int CNT_W = $clog2(DEPTH + 1);

    pf_state_t         state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0]  stale_q, stale_d;
    logic [CNT_W-1:0]  fifo_count_s;
    pf_entry_t         head_s, push_entry_s;
    logic [ADDR_W-1:0] rsp_pc_s;
    logic              has_credit_s, req_valid_s, req_fire_s;
    logic              rsp_fetch_s, rsp_stale_s, rsp_take_s;
    logic              head_valid_s, bypass_s, push_s, pop_s;
    logic              unused_pc_bits_s;

    assign unused_pc_bits_s = ^redirect_pc[1:0];

    // Handshake qualification; the oldest in-flight PC trails fetch_pc by one word per outstanding request.
    always_comb begin
        has_credit_s = ({1'b0, fifo_count_s} + {1'b0, out_cnt_q}) < (CNT_W + 1)'(DEPTH);
        req_valid_s  = reset && (state_q == FETCH) && has_credit_s && !redirect_valid;
        req_fire_s   = req_valid_s && imem_req_ready;
        rsp_fetch_s  = imem_rsp_valid && (state_q == FETCH) && (out_cnt_q != {CNT_W{1'b0}});
        rsp_stale_s  = imem_rsp_valid && (state_q == FLUSH) && (stale_q != {CNT_W{1'b0}});
        rsp_take_s   = rsp_fetch_s || rsp_stale_s;
        rsp_pc_s     = fetch_pc_q - (ADDR_W'(out_cnt_q) << 2);
        head_valid_s = reset && (fifo_count_s != {CNT_W{1'b0}});
`ifdef PREFETCH_BYPASS_EN
        bypass_s     = rsp_fetch_s && !redirect_valid && (fifo_count_s == {CNT_W{1'b0}});
`else
        bypass_s     = 1'b0;
`endif
        push_s       = rsp_fetch_s && !redirect_valid && !(bypass_s && instr_ready);
        pop_s        = head_valid_s && instr_ready && !redirect_valid;
        push_entry_s.pc    = rsp_pc_s;
        push_entry_s.instr = imem_rsp_data;
    end

    // Output drive: bypassed response, queue head, or zeros when idle.
    always_comb begin
        imem_req_valid = req_valid_s;
        imem_req_addr  = fetch_pc_q;
        instr_valid    = head_valid_s || bypass_s;
        if (bypass_s) begin
            instr_data = imem_rsp_data;
            instr_pc   = rsp_pc_s;
        end else if (head_valid_s) begin
            instr_data = head_s.instr;
            instr_pc   = head_s.pc;
        end else begin
            instr_data = {INSTR_W{1'b0}};
            instr_pc   = {ADDR_W{1'b0}};
        end
    end

    // Next-state logic: on redirect everything in flight becomes stale.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        out_cnt_d  = out_cnt_q;
        stale_d    = stale_q;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
            out_cnt_d  = {CNT_W{1'b0}};
            stale_d    = stale_q + out_cnt_q + CNT_W'(req_fire_s) - CNT_W'(rsp_take_s);
        end else begin
            if (req_fire_s) begin
                fetch_pc_d = fetch_pc_q + ADDR_W'(3'd4);
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            out_cnt_d = out_cnt_q + CNT_W'(req_fire_s) - CNT_W'(rsp_fetch_s);
            stale_d   = stale_q - CNT_W'(rsp_stale_s);
        end
        case (state_q)
            FETCH: begin
                if (redirect_valid && ((out_cnt_q != {CNT_W{1'b0}}) || req_fire_s)) begin
                    state_d = FLUSH;
                end else begin
                    state_d = FETCH;
                end
            end
            FLUSH: begin
                if (stale_d == {CNT_W{1'b0}}) begin
                    state_d = FETCH;
                end else begin
                    state_d = FLUSH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= FETCH;
            fetch_pc_q <= RESET_PC;
            out_cnt_q  <= {CNT_W{1'b0}};
            stale_q    <= {CNT_W{1'b0}};
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            out_cnt_q  <= out_cnt_d;
            stale_q    <= stale_d;
        end
    end

    prefetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clk),
        .rst_ni      (reset),
        .clear_i     (redirect_valid),
        .push_i      (push_s),
        .push_data_i (push_entry_s),
        .pop_i       (pop_s),
        .head_o      (head_s),
        .count_o     (fifo_count_s)
    );

    prefetch_checker u_checker (
        .clk_i        (clk),
        .rst_ni       (reset),
        .rsp_valid_i  (imem_rsp_valid),
        .out_zero_i   (out_cnt_q == {CNT_W{1'b0}}),
        .stale_zero_i (stale_q == {CNT_W{1'b0}})
    );

endmodule

// File: doc/instr_prefetch_queue.md
Name: instr_prefetch_queue

Overview:
- Sits directly upstream of the IF stage and downstream of instruction memory.
- Issues sequential word fetches to a variable-latency, in-order instruction memory, and buffers the returned instructions with their PCs in a small queue.
- Presents one instruction per cycle to IF under a valid/ready handshake.
- On a branch redirect from RF/EX, flushes the queue and discards in-flight stale responses.

Parameters:
- DEPTH, 4: queue entries; also the cap on (queued + outstanding) requests.
- ADDR_W, 64: PC width.
- INSTR_W, 32: instruction width.
- RESET_PC, 0: fetch PC after reset.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-low; reset==0 at a posedge resets all state.
- redirect_valid  in  1  branch taken; flush and restart at redirect_pc.
- redirect_pc  in  ADDR_W  new fetch PC; low 2 bits ignored (forced 0).
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  ADDR_W  fetch address.
- imem_rsp_valid  in  1  response data valid; responses are in order, no backpressure.
- imem_rsp_data  in  INSTR_W  fetched instruction.
- instr_valid  out  1  head entry valid.
- instr_data  out  INSTR_W  head instruction.
- instr_pc  out  ADDR_W  head PC.
- instr_ready  in  1  IF consumes head; low while IF is stalled.

Behaviour:
- Reset (reset==0 at posedge):
  - fetch_pc=RESET_PC, queue empty, outstanding=0, stale=0, state=FETCH.
  - Outputs: imem_req_valid=0, instr_valid=0, imem_req_addr=RESET_PC, instr_data=0, instr_pc=0.
  - Reset overrides every other input in the same cycle.
- Credit rule:
  - credits = DEPTH − (count + outstanding).
  - imem_req_valid = (state==FETCH) && credits>0 && !redirect_valid.
  - imem_req_addr = fetch_pc.
  - The queue can never overflow.
- Request handshake (valid && ready): fetch_pc += 4 (wraps modulo 2^ADDR_W), outstanding += 1.
- Response in FETCH:
  - Enqueue {imem_rsp_data, pc of oldest outstanding}; outstanding −= 1.
  - A PC FIFO of outstanding request addresses, or the equivalent counter-based rule, supplies the PC.
- Dequeue: instr_valid = count>0. On instr_valid && instr_ready, pop the head.
- Enqueue and dequeue in the same cycle are allowed, including at full. Count is unchanged.
- Latency: a request accepted in cycle N with its response in cycle N+k gives instr_valid in cycle N+k+1 (registered queue).
- FSM states FETCH and FLUSH.
  - FETCH → FLUSH when redirect_valid && outstanding>0 (after counting any same-cycle handshake).
  - FETCH → FETCH on redirect when no requests are outstanding.
  - FLUSH: no requests issued. Each response decrements stale and is dropped.
  - FLUSH → FETCH in the cycle after stale reaches 0.
- On redirect (either state):
  - Queue cleared; fetch_pc = {redirect_pc[ADDR_W-1:2],2'b00}.
  - stale = outstanding, plus 1 if a request handshakes this cycle, minus 1 if a response arrives this cycle; outstanding = 0.
- Simultaneous events on a redirect cycle:
  - A response arriving in the same cycle is discarded.
  - A same-cycle dequeue handshake is ignored; the queue is cleared regardless.
  - Redirect during FLUSH: new PC replaces the old one; stale keeps counting down.
- Responses with outstanding==0 and stale==0 are a protocol error: ignored, and flagged by a simulation assertion.

Optional Feature:
- PREFETCH_BYPASS_EN defined:
  - When the queue is empty, state==FETCH, imem_rsp_valid=1 and redirect_valid=0, the response drives instr_valid/instr_data/instr_pc combinationally in the same cycle.
  - If instr_ready=1 it is consumed without being enqueued. Otherwise it is enqueued.
  - Latency becomes N+k.
- Undefined: responses are always enqueued first.

Decomposition:
- Package prefetch_pkg holds:
  - ADDR_W, INSTR_W, RESET_PC defaults.
  - typedef enum logic {FETCH, FLUSH} pf_state_t.
  - typedef struct packed {logic [ADDR_W-1:0] pc; logic [INSTR_W-1:0] instr;} pf_entry_t.
- Sub-module prefetch_fifo: DEPTH-entry circular FIFO of pf_entry_t with push, pop, clear, count, and wrap-around pointers.

Test Plan:
- Reset, imem_req_ready=1, 1-cycle memory, instr_ready=1 → addresses 0,4,8,… issued; instr_pc follows 0,4,8 with matching data; no gaps after warm-up.
- instr_ready=0 for 10 cycles → exactly 4 requests total, count=4, imem_req_valid=0. Release → in-order drain from pc 0, and fetch resumes at 16.
- 3-cycle memory, 2 requests outstanding, redirect_pc=0x100 → queue empty next cycle; the 2 stale responses are dropped; first new request addr=0x100; instr_pc=0x100 first.
- Redirect to 0x203 in the same cycle as a response and a request handshake → both counted stale; next fetch addr=0x200.
- fetch_pc=0xFFFF_FFFF_FFFF_FFFC → next addr 0x0 (wrap).
- Response with nothing outstanding → assertion fires; queue unchanged.
- With PREFETCH_BYPASS_EN defined: empty queue plus a response → instr_valid in the same cycle.
